bias_load_ctrl: RTL and testbench

BIAS_LOAD_CTRL -- requirements
Module: bias_load_ctrl

---
 rtl/bias_load_ctrl_if.sv | 27 ++
 rtl/bias_load_ctrl.sv | 92 +++++++++
 tb/tb_bias_load_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bias_load_ctrl_if.sv
// Bias-load bus: serial word input on one side and the vector handed to the bias memory on the other.
// The master side (sequencer or bench) drives start and the serial word.
// The slave side (bias_load_ctrl) returns the handshake, the write strobe and status.
interface bias_load_ctrl_if #(
  parameter int NUM_FEATURES = 3,
  parameter int DATA_WIDTH   = 32
);
  logic                                  start;
  logic                                  in_valid;
  logic signed [DATA_WIDTH-1:0]          in_data;
  logic                                  in_ready;
  logic                                  bias_WrEn;
  logic [NUM_FEATURES:0][DATA_WIDTH-1:0] bias_weights_input;
  logic                                  busy;
  logic                                  bias_valid;
  logic                                  done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, bias_WrEn, bias_weights_input, busy, bias_valid, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, bias_WrEn, bias_weights_input, busy, bias_valid, done
  );
endinterface

// File: rtl/bias_load_ctrl.sv
// Bias vector loader.
// It collects NUM_FEATURES+1 serial words into a staging vector and then
// issues a single active-low write strobe to the bias memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; the last committed vector stays valid
// ST_LOAD   | accepting serial words into staging, index 0 first
// ST_COMMIT | bias_WrEn low for one cycle, staging held stable
// ST_DONE   | done pulse, bias_valid set; start here chains a new load
module bias_load_ctrl #(
  parameter int NUM_FEATURES = 3,
  parameter int DATA_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  bias_load_ctrl_if.slave  bus
);
  localparam int NW = NUM_FEATURES + 1;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_FEATURES);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_DONE} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  logic [NW-1:0][DATA_WIDTH-1:0] stage;
  logic                         bias_valid_q;
  logic                         accept;
  logic                         start_ok;

  assign accept   = (state == ST_LOAD) && bus.in_valid;
  assign start_ok = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;

  // State register; reset aborts any load in flight without a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    bus.in_ready  = 1'b0;
    bus.bias_WrEn = 1'b1;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (accept && (cnt == LAST)) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        bus.bias_WrEn = 1'b0;
        bus.busy      = 1'b1;
        state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        bus.done  = 1'b1;
        state_nxt = bus.start ? ST_LOAD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Word index; parks on the last index rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (start_ok)               cnt <= '0;
    else if (accept && cnt != LAST)  cnt <= cnt + 1'b1;
  end

  // Staging vector; entries not written this load keep their old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        stage      <= '0;
    else if (accept) stage[cnt] <= bus.in_data;
  end

  // Committed-vector flag: set entering DONE, dropped when a new load starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     bias_valid_q <= 1'b0;
    else if (start_ok)            bias_valid_q <= 1'b0;
    else if (state == ST_COMMIT)  bias_valid_q <= 1'b1;
  end

  assign bus.bias_weights_input = stage;
  assign bus.bias_valid         = bias_valid_q;
endmodule

// File: tb/tb_bias_load_ctrl.sv
// Bench for bias_load_ctrl.
// The driver pushes the vector each load is expected to commit.
// A negedge monitor pops that vector on every write strobe and checks the memory-side outputs.
module tb_bias_load_ctrl;
  localparam int NF = 3;
  localparam int DW = 32;

  typedef logic [NF:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   strobes = 0;
  int   loads   = 0;
  bit   exp_done = 1'b0;
  vec_t exp_q[$];

  bias_load_ctrl_if #(.NUM_FEATURES(NF), .DATA_WIDTH(DW)) bus ();

  bias_load_ctrl #(.NUM_FEATURES(NF), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  // Scoreboard monitor: each strobe must match the oldest expected vector, then done follows.
  always @(negedge clk) begin
    vec_t v;
    if (rst) begin
      if (exp_done || bus.done) begin
        chk("done_pulse", 64'(bus.done), 64'(exp_done));
        if (exp_done) chk("bias_valid_in_done", 64'(bus.bias_valid), 64'(1));
      end
      exp_done = 1'b0;
      if (!bus.bias_WrEn) begin
        strobes++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL strobe_unexpected: strobe seen with no load pending at %0t", $time);
        end else begin
          v = exp_q.pop_front();
          for (int i = 0; i <= NF; i++)
            chk("commit_word", 64'(bus.bias_weights_input[i]), 64'(v[i]));
        end
        exp_done = 1'b1;
      end
    end else begin
      exp_done = 1'b0;
    end
  end

  // One load. chained=1 means the caller is in the COMMIT cycle and start is held into DONE.
  task automatic run_load(input vec_t w, input int gap, input bit mid_start,
                          input bit extra, input bit chained);
    exp_q.push_back(w);
    loads++;
    if (!chained) begin
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end else begin
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    chk("busy_in_load", 64'(bus.busy), 64'(1));
    chk("bias_valid_cleared", 64'(bus.bias_valid), 64'(0));
    for (int i = 0; i <= NF; i++) begin
      for (int g = 0; (i > 0) && (g < gap); g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        chk("in_ready_bubble", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
      end
      if (mid_start && i == 2) bus.start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = w[i];
      chk("in_ready_word", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    chk("strobe_after_last_word", 64'(bus.bias_WrEn), 64'(0));
    if (extra) begin
      bus.in_data = $urandom;
      chk("in_ready_extra", 64'(bus.in_ready), 64'(0));
      @(posedge clk);
      #1;
      for (int i = 0; i <= NF; i++)
        chk("vector_after_extra", 64'(bus.bias_weights_input[i]), 64'(w[i]));
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vec_t w;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_wren", 64'(bus.bias_WrEn), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_bias_valid", 64'(bus.bias_valid), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_vector", 64'(bus.bias_weights_input == '0), 64'(1));
    #10 rst = 1'b1;

    run_load(mkv(10, -5, 7, 32'h7FFFFFFF), 0, 1'b0, 1'b0, 1'b0);
    run_load(mkv(10, -5, 7, 32'h7FFFFFFF), 3, 1'b0, 1'b0, 1'b0);
    run_load(mkv(21, -33, 44, -55), 1, 1'b1, 1'b0, 1'b0);

    // Abort: reset after the first word is accepted.
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd1234;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'(0));
    chk("abort_wren", 64'(bus.bias_WrEn), 64'(1));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_bias_valid", 64'(bus.bias_valid), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_vector", 64'(bus.bias_weights_input == '0), 64'(1));
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_stays_idle", 64'(bus.busy), 64'(0));

    run_load(mkv(1, 2, 3, 4), 0, 1'b0, 1'b0, 1'b0);
    run_load(mkv(-1, -2, -3, -4), 0, 1'b0, 1'b0, 1'b1);
    run_load(mkv(5, 6, 7, 8), 0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i <= NF; i++) w[i] = $urandom;
      run_load(w, int'($urandom_range(0, 3)), 1'(k[0]), 1'(k == 4), 1'b0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("strobe_count", 64'(strobes), 64'(loads));
    chk("final_bias_valid", 64'(bus.bias_valid), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
